// File: rtl/icache_refill_pkg.sv
// Shared types and constants for the icache line-refill responder.
package icache_refill_pkg;

  localparam int LINE_BYTES = 64;
  localparam int DATA_W     = 64;
  localparam int BEATS      = LINE_BYTES * 8 / DATA_W;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/icache_refill_axi.sv
// icache line-refill responder: one AXI4 INCR burst per request, line held
// in a local register array and presented word by word until released.
//
//  state | meaning
//  IDLE  | waiting for a refill request (blocked while fifo_done_i is high)
//  AR    | arvalid_o asserted with the aligned line address, waiting arready_i
//  R     | rready_o asserted, collecting beats into the line buffer
//  DONE  | line buffered, done_o high, data_o follows fifo_idx_i
module icache_refill_axi
  import icache_refill_pkg::*;
#(
  parameter int LINE_BYTES = icache_refill_pkg::LINE_BYTES,
  parameter int DATA_W     = icache_refill_pkg::DATA_W,
  parameter int AXI_ID     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [63:0]       req_addr_i,
  input  logic [8:0]        fifo_idx_i,
  input  logic              fifo_done_i,
  output logic              done_o,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o,
  output logic [3:0]        arid_o,
  output logic [63:0]       araddr_o,
  output logic [7:0]        arlen_o,
  output logic [2:0]        arsize_o,
  output logic [1:0]        arburst_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rlast_i,
  input  logic              rvalid_i,
  output logic              rready_o
);

  localparam int N_BEATS  = LINE_BYTES * 8 / DATA_W;
  localparam int CNT_W    = $clog2(N_BEATS);
  localparam int IDX_LSB  = $clog2(DATA_W);
  localparam logic [63:0]      OFFS_MASK = 64'(LINE_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(N_BEATS - 1);

  state_e             state_q, state_d;
  logic [63:0]        araddr_q, araddr_d;
  logic               arvalid_q, arvalid_d;
  logic               rready_q, rready_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  line_buf_q [N_BEATS];
  logic               beat_fire;
  logic               beat_last;
  logic               buf_we;

  // Word-select bits below the word boundary carry no information.
  logic unused_idx_bits;
  assign unused_idx_bits = ^fifo_idx_i[IDX_LSB-1:0];

  assign beat_fire = rvalid_i && rready_q;
  assign beat_last = (cnt_q == LAST_CNT) || rlast_i;

  // Next-state and next-output computation for the refill sequencer.
  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    done_d    = done_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    buf_we    = 1'b0;
    case (state_q)
      IDLE: begin
        // A release overlapping the request drop must not restart a refill.
        if (req_i && !fifo_done_i) begin
          araddr_d  = req_addr_i & ~OFFS_MASK;
          err_d     = 1'b0;
          cnt_d     = '0;
          arvalid_d = 1'b1;
          state_d   = AR;
        end
      end
      AR: begin
        if (arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = R;
        end
      end
      R: begin
        if (beat_fire) begin
          buf_we = 1'b1;
          if (rresp_i != AXI_RESP_OKAY) err_d = 1'b1;
          if (beat_last) begin
            // RLAST must coincide exactly with the final beat; any other
            // arrangement still terminates but flags the line as bad.
            if (!((cnt_q == LAST_CNT) && rlast_i)) err_d = 1'b1;
            rready_d = 1'b0;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (fifo_done_i || !req_i) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and AXI output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Line buffer is data-only storage; its contents are meaningless until done_o.
  always_ff @(posedge clk) begin
    if (buf_we) line_buf_q[cnt_q] <= rdata_i;
  end

  assign arid_o    = 4'(AXI_ID);
  assign araddr_o  = araddr_q;
  assign arlen_o   = 8'(N_BEATS - 1);
  assign arsize_o  = AXI_SIZE_8B;
  assign arburst_o = AXI_BURST_INCR;
  assign arvalid_o = arvalid_q;
  assign rready_o  = rready_q;
  assign done_o    = done_q;
  // The sticky error accumulates during the burst but is only reported with the line.
  assign err_o     = err_q & done_q;
  assign data_o    = line_buf_q[fifo_idx_i[IDX_LSB +: CNT_W]];

endmodule

// File: tb/tb_icache_refill_axi.sv
// Randomized bench for icache_refill_axi with a line-level reference model.
module tb_icache_refill_axi;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic [63:0] req_addr_i;
  logic [8:0]  fifo_idx_i;
  logic        fifo_done_i;
  logic        done_o;
  logic [63:0] data_o;
  logic        err_o;
  logic [3:0]  arid_o;
  logic [63:0] araddr_o;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        arvalid_o;
  logic        arready_i;
  logic [63:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rlast_i;
  logic        rvalid_i;
  logic        rready_o;

  int n_chk = 0;
  int n_err = 0;

  // Reference line: words known to be held by the buffer.
  logic [63:0] m_buf [8];
  bit          m_vld [8];
  // Per-refill memory response script.
  logic [63:0] t_data [8];
  logic [1:0]  t_resp [8];

  icache_refill_axi dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .req_addr_i (req_addr_i),
    .fifo_idx_i (fifo_idx_i),
    .fifo_done_i(fifo_done_i),
    .done_o     (done_o),
    .data_o     (data_o),
    .err_o      (err_o),
    .arid_o     (arid_o),
    .araddr_o   (araddr_o),
    .arlen_o    (arlen_o),
    .arsize_o   (arsize_o),
    .arburst_o  (arburst_o),
    .arvalid_o  (arvalid_o),
    .arready_i  (arready_i),
    .rdata_i    (rdata_i),
    .rresp_i    (rresp_i),
    .rlast_i    (rlast_i),
    .rvalid_i   (rvalid_i),
    .rready_o   (rready_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_done"},    64'(done_o),    64'd0);
    chk({tag, "_err"},     64'(err_o),     64'd0);
    chk({tag, "_arvalid"}, 64'(arvalid_o), 64'd0);
    chk({tag, "_rready"},  64'(rready_o),  64'd0);
  endtask

  task automatic check_line(input bit exp_err);
    chk("line_done", 64'(done_o), 64'd1);
    chk("line_err",  64'(err_o),  64'(exp_err));
    for (int i = 0; i < 8; i++) begin
      fifo_idx_i = 9'(i * 64) | 9'($urandom_range(0, 63));
      #1;
      if (m_vld[i]) chk($sformatf("data%0d", i), data_o, m_buf[i]);
    end
  endtask

  // One full refill. last_pos = beat index carrying RLAST (8 = never asserted).
  task automatic run_refill(input logic [63:0] addr, input int last_pos,
                            input int ar_delay, input logic [7:0] gaps);
    logic [63:0] exp_a;
    bit          exp_err;
    int          end_b;
    exp_a   = addr & ~64'h3f;
    end_b   = (last_pos < 8) ? last_pos : 7;
    exp_err = (last_pos != 7);
    for (int b = 0; b <= end_b; b++) if (t_resp[b] != 2'b00) exp_err = 1'b1;

    req_addr_i = addr;
    req_i      = 1'b1;
    step();
    chk("ar_valid",  64'(arvalid_o), 64'd1);
    chk("ar_addr",   araddr_o,       exp_a);
    chk("ar_len",    64'(arlen_o),   64'd7);
    chk("ar_size",   64'(arsize_o),  64'd3);
    chk("ar_burst",  64'(arburst_o), 64'd1);
    chk("ar_id",     64'(arid_o),    64'd0);
    // Request fields must be ignored once the refill is under way.
    req_addr_i = {$urandom, $urandom};
    for (int d = 0; d < ar_delay; d++) begin
      step();
      chk("ar_hold_valid", 64'(arvalid_o), 64'd1);
      chk("ar_hold_addr",  araddr_o,       exp_a);
    end
    arready_i = 1'b1;
    step();
    arready_i = 1'b0;
    chk("ar_drop", 64'(arvalid_o), 64'd0);
    chk("r_ready", 64'(rready_o),  64'd1);

    for (int b = 0; b <= end_b; b++) begin
      if (gaps[b]) begin
        rvalid_i = 1'b0;
        step();
        chk("gap_rready", 64'(rready_o), 64'd1);
      end
      rvalid_i = 1'b1;
      rdata_i  = t_data[b];
      rresp_i  = t_resp[b];
      rlast_i  = (b == last_pos);
      step();
      m_buf[b] = t_data[b];
      m_vld[b] = 1'b1;
      if (b < end_b) chk("done_early", 64'(done_o), 64'd0);
    end
    rvalid_i = 1'b0;
    rlast_i  = 1'b0;
    rresp_i  = 2'b00;
    chk("r_end_rready", 64'(rready_o), 64'd0);
    check_line(exp_err);
  endtask

  task automatic release_line(input bit with_done);
    req_i       = 1'b0;
    fifo_done_i = with_done;
    step();
    fifo_done_i = 1'b0;
    chk_idle_outputs("release");
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_vld[i] = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_i = 1'b0; req_addr_i = '0; fifo_idx_i = '0; fifo_done_i = 1'b0;
    arready_i = 1'b0; rdata_i = '0; rresp_i = 2'b00; rlast_i = 1'b0; rvalid_i = 1'b0;
    clear_model();
    step();
    step();
    chk_idle_outputs("reset");
    rst = 1'b1;
    step();

    // Basic line.
    for (int b = 0; b < 8; b++) begin t_data[b] = 64'(8'h11 * (b + 1)); t_resp[b] = 2'b00; end
    run_refill(64'h8000_1234, 7, 0, 8'h00);
    release_line(1'b1);

    // Backpressure on AR and gaps on R.
    for (int b = 0; b < 8; b++) t_data[b] = {$urandom, $urandom};
    run_refill(64'h0000_0040_dead_beef, 7, 5, 8'b0010_0100);
    release_line(1'b1);

    // SLVERR on one beat, then abort by request drop.
    for (int b = 0; b < 8; b++) t_data[b] = {$urandom, $urandom};
    t_resp[3] = 2'b10;
    run_refill(64'h1234_5678_0000_00ff, 7, 1, 8'h00);
    t_resp[3] = 2'b00;
    release_line(1'b0);

    // RLAST on the sixth beat: early end, stale upper words keep old values.
    for (int b = 0; b < 8; b++) t_data[b] = {$urandom, $urandom};
    run_refill(64'h0000_0000_0000_1fc0, 5, 0, 8'h00);
    release_line(1'b1);

    // A release held high blocks a new start.
    req_i = 1'b1; fifo_done_i = 1'b1; req_addr_i = 64'h40;
    step();
    chk("blocked_arvalid", 64'(arvalid_o), 64'd0);
    step();
    chk("blocked_arvalid2", 64'(arvalid_o), 64'd0);
    fifo_done_i = 1'b0;
    for (int b = 0; b < 8; b++) t_data[b] = {$urandom, $urandom};
    run_refill(64'h0000_0000_0000_0080, 7, 0, 8'h00);
    release_line(1'b1);

    // Reset in the middle of the R phase.
    req_addr_i = 64'h9000; req_i = 1'b1;
    step();
    arready_i = 1'b1;
    step();
    arready_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      rvalid_i = 1'b1; rdata_i = {$urandom, $urandom}; rresp_i = 2'b00;
      step();
    end
    rvalid_i = 1'b0; req_i = 1'b0; rst = 1'b0;
    step();
    chk_idle_outputs("midr_reset");
    rst = 1'b1;
    clear_model();
    step();
    chk("post_reset_arvalid", 64'(arvalid_o), 64'd0);
    for (int b = 0; b < 8; b++) t_data[b] = {$urandom, $urandom};
    run_refill(64'h0000_0000_0000_9000, 7, 2, 8'h81);
    release_line(1'b1);

    // Randomized refills.
    for (int n = 0; n < 25; n++) begin
      int lp;
      for (int b = 0; b < 8; b++) begin
        t_data[b] = {$urandom, $urandom};
        t_resp[b] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end
      lp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : 7;
      run_refill({$urandom, $urandom}, lp, int'($urandom_range(0, 3)), 8'($urandom));
      release_line(1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
